vsetvl_stripminer: RTL and testbench

VSETVL_STRIPMINER -- requirements
Module: vsetvl_stripminer

---
 rtl/vcfg_pkg.sv | 34 +++
 rtl/vlmax_calc.sv | 21 ++
 rtl/vsetvl_stripminer.sv | 124 ++++++++++++
 tb/tb_vsetvl_stripminer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vcfg_pkg.sv
// Shared vector-configuration types: SEW/LMUL encodings, vtype layout and
// the strip-miner FSM states.
package vcfg_pkg;

  typedef enum logic [2:0] {
    SEW_8  = 3'd0,
    SEW_16 = 3'd1,
    SEW_32 = 3'd2,
    SEW_64 = 3'd3
  } sew_e;

  typedef enum logic [2:0] {
    LMUL_1 = 3'd0,
    LMUL_2 = 3'd1,
    LMUL_4 = 3'd2,
    LMUL_8 = 3'd3
  } lmul_e;

  // vtype bit 6 = vill, [5:3] = sew, [2:0] = lmul
  typedef struct packed {
    logic  vill;
    sew_e  sew;
    lmul_e lmul;
  } vtype_t;

  localparam int VTYPE_W = 7;
  localparam vtype_t VTYPE_ILLEGAL = '{vill: 1'b1, sew: SEW_8, lmul: LMUL_1};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STRIP = 1'b1
  } state_e;

endpackage

// File: rtl/vlmax_calc.sv
// Combinational VLMAX and legality check for a SEW/LMUL encoding pair.
module vlmax_calc #(
  parameter int VLEN  = 128,
  parameter int ELEN  = 64,
  parameter int AVL_W = 16
) (
  input  logic [2:0]       sew,
  input  logic [2:0]       lmul,
  output logic [AVL_W-1:0] vlmax,
  output logic             illegal
);

  localparam logic [AVL_W-1:0] VLEN_W = AVL_W'(VLEN);

  always_comb begin
    illegal = (sew > 3'd3) || (lmul > 3'd3) || ((32'd8 << sew) > 32'(ELEN));
    // Illegal encodings report zero so a stray shift never leaks through.
    vlmax   = illegal ? '0 : ((VLEN_W >> ({1'b0, sew} + 4'd3)) << lmul);
  end

endmodule

// File: rtl/vsetvl_stripminer.sv
// Accepts a vtype/AVL configuration and hands out successive strips of
// at most VLMAX elements until the AVL is exhausted or aborted.
module vsetvl_stripminer
  import vcfg_pkg::*;
#(
  parameter int VLEN  = 128,
  parameter int ELEN  = 64,
  parameter int AVL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [2:0]         cfg_sew,
  input  logic [2:0]         cfg_lmul,
  input  logic [AVL_W-1:0]   cfg_avl,
  input  logic               strip_next,
  input  logic               abort,
  output logic [AVL_W-1:0]   vl,
  output logic [VTYPE_W-1:0] vtype,
  output logic [AVL_W-1:0]   avl_rem,
  output logic               strip_valid,
  output logic               done,
  output logic               cfg_err
);

  state_e           state_q;
  vtype_t           vtype_q;
  logic [2:0]       calc_sew;
  logic [2:0]       calc_lmul;
  logic [AVL_W-1:0] vlmax;
  logic             illegal;
  logic [AVL_W-1:0] src_avl;
  logic [AVL_W-1:0] take;

  // One calculator serves both the incoming config and the latched vtype.
  always_comb begin
    calc_sew  = cfg_sew;
    calc_lmul = cfg_lmul;
    src_avl   = cfg_avl;
    if (state_q == ST_STRIP) begin
      calc_sew  = vtype_q.sew;
      calc_lmul = vtype_q.lmul;
      src_avl   = avl_rem;
    end
    take = (src_avl < vlmax) ? src_avl : vlmax;
  end

  vlmax_calc #(
    .VLEN  (VLEN),
    .ELEN  (ELEN),
    .AVL_W (AVL_W)
  ) u_vlmax_calc (
    .sew     (calc_sew),
    .lmul    (calc_lmul),
    .vlmax   (vlmax),
    .illegal (illegal)
  );

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vtype_q     <= VTYPE_ILLEGAL;
      vl          <= '0;
      avl_rem     <= '0;
      cfg_ready   <= 1'b1;
      strip_valid <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_valid) begin
            vl      <= '0;
            avl_rem <= '0;
            if (illegal) begin
              vtype_q <= VTYPE_ILLEGAL;
              cfg_err <= 1'b1;
            end else begin
              vtype_q <= '{vill: 1'b0, sew: sew_e'(cfg_sew), lmul: lmul_e'(cfg_lmul)};
              if (cfg_avl == '0) begin
                done <= 1'b1;
              end else begin
                vl          <= take;
                avl_rem     <= cfg_avl - take;
                state_q     <= ST_STRIP;
                cfg_ready   <= 1'b0;
                strip_valid <= 1'b1;
              end
            end
          end
        end
        ST_STRIP: begin
          if (abort) begin
            state_q     <= ST_IDLE;
            vl          <= '0;
            avl_rem     <= '0;
            cfg_ready   <= 1'b1;
            strip_valid <= 1'b0;
          end else if (strip_next) begin
            if (avl_rem != '0) begin
              vl      <= take;
              avl_rem <= avl_rem - take;
            end else begin
              state_q     <= ST_IDLE;
              vl          <= '0;
              cfg_ready   <= 1'b1;
              strip_valid <= 1'b0;
              done        <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign vtype = vtype_q;

endmodule

// File: tb/tb_vsetvl_stripminer.sv
// Directed bench for vsetvl_stripminer: strip sequences, illegal configs,
// zero AVL, abort and asynchronous reset.
module tb_vsetvl_stripminer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_valid32;
  logic [2:0]  cfg_sew, cfg_lmul;
  logic [15:0] cfg_avl;
  logic        strip_next, abort;

  logic        cfg_ready, strip_valid, done, cfg_err;
  logic [15:0] vl, avl_rem;
  logic [6:0]  vtype;

  logic        cfg_ready32, strip_valid32, done32, cfg_err32;
  logic [15:0] vl32, avl_rem32;
  logic [6:0]  vtype32;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vsetvl_stripminer #(.VLEN(128), .ELEN(64), .AVL_W(16)) dut (
    .clk (clk), .rst (rst),
    .cfg_valid (cfg_valid), .cfg_ready (cfg_ready),
    .cfg_sew (cfg_sew), .cfg_lmul (cfg_lmul), .cfg_avl (cfg_avl),
    .strip_next (strip_next), .abort (abort),
    .vl (vl), .vtype (vtype), .avl_rem (avl_rem),
    .strip_valid (strip_valid), .done (done), .cfg_err (cfg_err)
  );

  vsetvl_stripminer #(.VLEN(128), .ELEN(32), .AVL_W(16)) dut32 (
    .clk (clk), .rst (rst),
    .cfg_valid (cfg_valid32), .cfg_ready (cfg_ready32),
    .cfg_sew (cfg_sew), .cfg_lmul (cfg_lmul), .cfg_avl (cfg_avl),
    .strip_next (strip_next), .abort (abort),
    .vl (vl32), .vtype (vtype32), .avl_rem (avl_rem32),
    .strip_valid (strip_valid32), .done (done32), .cfg_err (cfg_err32)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_valid = 0; cfg_valid32 = 0; cfg_sew = 0; cfg_lmul = 0;
    cfg_avl = 0; strip_next = 0; abort = 0;
    #2;
    check("rst_vl", 32'(vl), 0);
    check("rst_avl_rem", 32'(avl_rem), 0);
    check("rst_vtype", 32'(vtype), 32'h40);
    check("rst_strip_valid", 32'(strip_valid), 0);
    check("rst_done_err", {30'd0, done, cfg_err}, 0);
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    #10 rst = 1'b0;   // released between edges

    // sew=8, lmul=1, avl=40: VLMAX=16 -> 16/24, 16/8, 8/0, done
    cfg_valid = 1; cfg_sew = 3'd0; cfg_lmul = 3'd0; cfg_avl = 16'd40;
    step(); cfg_valid = 0;
    check("a40_s1_vl", 32'(vl), 16);
    check("a40_s1_rem", 32'(avl_rem), 24);
    check("a40_s1_valid", 32'(strip_valid), 1);
    check("a40_s1_ready", 32'(cfg_ready), 0);
    check("a40_s1_vtype", 32'(vtype), 32'h00);
    cfg_valid = 1; cfg_sew = 3'd2; cfg_avl = 16'd3;     // ignored in STRIP
    step(); cfg_valid = 0;
    check("strip_cfg_ignored_vl", 32'(vl), 16);
    check("strip_cfg_ignored_rem", 32'(avl_rem), 24);
    strip_next = 1;
    step();
    check("a40_s2_vl", 32'(vl), 16);
    check("a40_s2_rem", 32'(avl_rem), 8);
    step();
    check("a40_s3_vl", 32'(vl), 8);
    check("a40_s3_rem", 32'(avl_rem), 0);
    check("a40_s3_done", 32'(done), 0);
    step(); strip_next = 0;
    check("a40_done", 32'(done), 1);
    check("a40_idle_valid", 32'(strip_valid), 0);
    check("a40_idle_vl", 32'(vl), 0);
    check("a40_idle_ready", 32'(cfg_ready), 1);
    step();
    check("a40_done_pulse", 32'(done), 0);

    // sew=32, lmul=8: VLMAX=32, avl=20 fits in one strip
    cfg_valid = 1; cfg_sew = 3'd2; cfg_lmul = 3'd3; cfg_avl = 16'd20;
    step(); cfg_valid = 0;
    check("a20_vl", 32'(vl), 20);
    check("a20_rem", 32'(avl_rem), 0);
    check("a20_vtype", 32'(vtype), 32'h13);
    strip_next = 1;
    step(); strip_next = 0;
    check("a20_done", 32'(done), 1);
    check("a20_ready", 32'(cfg_ready), 1);

    // sew code 4 is illegal
    cfg_valid = 1; cfg_sew = 3'd4; cfg_lmul = 3'd0; cfg_avl = 16'd10;
    step(); cfg_valid = 0;
    check("sew4_vtype", 32'(vtype), 32'h40);
    check("sew4_vl", 32'(vl), 0);
    check("sew4_err", 32'(cfg_err), 1);
    check("sew4_ready", 32'(cfg_ready), 1);
    check("sew4_no_strip", 32'(strip_valid), 0);
    step();
    check("sew4_err_pulse", 32'(cfg_err), 0);

    // lmul code 5 is illegal
    cfg_valid = 1; cfg_sew = 3'd0; cfg_lmul = 3'd5; cfg_avl = 16'd10;
    step(); cfg_valid = 0;
    check("lmul5_err", {31'd0, cfg_err}, 1);
    check("lmul5_vtype", 32'(vtype), 32'h40);

    // ELEN=32 rejects sew=64
    cfg_valid32 = 1; cfg_sew = 3'd3; cfg_lmul = 3'd0; cfg_avl = 16'd10;
    step(); cfg_valid32 = 0;
    check("elen32_vtype", 32'(vtype32), 32'h40);
    check("elen32_err", 32'(cfg_err32), 1);
    check("elen32_ready", 32'(cfg_ready32), 1);
    check("elen32_vl", 32'(vl32), 0);

    // legal zero AVL: done without entering STRIP
    cfg_valid = 1; cfg_sew = 3'd1; cfg_lmul = 3'd1; cfg_avl = 16'd0;
    step(); cfg_valid = 0;
    check("avl0_done", 32'(done), 1);
    check("avl0_vl", 32'(vl), 0);
    check("avl0_vtype", 32'(vtype), 32'h09);
    check("avl0_no_strip", 32'(strip_valid), 0);
    check("avl0_ready", 32'(cfg_ready), 1);

    // abort and strip_next in IDLE are ignored
    abort = 1; strip_next = 1;
    step(); abort = 0; strip_next = 0;
    check("idle_ignore_ready", 32'(cfg_ready), 1);
    check("idle_ignore_done", 32'(done), 0);

    // abort wins over strip_next on the second strip
    cfg_valid = 1; cfg_sew = 3'd0; cfg_lmul = 3'd0; cfg_avl = 16'd40;
    step(); cfg_valid = 0;
    strip_next = 1;
    step();
    check("ab_s2_vl", 32'(vl), 16);
    abort = 1;
    step(); abort = 0; strip_next = 0;
    check("ab_vl", 32'(vl), 0);
    check("ab_rem", 32'(avl_rem), 0);
    check("ab_vtype_kept", 32'(vtype), 32'h00);
    check("ab_no_done", 32'(done), 0);
    check("ab_ready", 32'(cfg_ready), 1);
    check("ab_valid", 32'(strip_valid), 0);
    step();
    check("ab_no_done_later", 32'(done), 0);

    // asynchronous reset mid-strip
    cfg_valid = 1; cfg_sew = 3'd1; cfg_lmul = 3'd2; cfg_avl = 16'd40;
    step(); cfg_valid = 0;
    check("ar_pre_vl", 32'(vl), 32);
    #2 rst = 1'b1;
    #1;
    check("ar_vl", 32'(vl), 0);
    check("ar_rem", 32'(avl_rem), 0);
    check("ar_vtype", 32'(vtype), 32'h40);
    check("ar_valid", 32'(strip_valid), 0);
    check("ar_ready", 32'(cfg_ready), 1);
    #2 rst = 1'b0;
    cfg_valid = 1; cfg_sew = 3'd2; cfg_lmul = 3'd0; cfg_avl = 16'd5;
    step(); cfg_valid = 0;
    check("ar_new_vl", 32'(vl), 4);
    check("ar_new_rem", 32'(avl_rem), 1);
    check("ar_new_no_done", 32'(done), 0);
    strip_next = 1;
    step();
    check("ar_s2_vl", 32'(vl), 1);
    check("ar_s2_rem", 32'(avl_rem), 0);
    step(); strip_next = 0;
    check("ar_done", 32'(done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
